// File: rtl/riscv_pkg.sv
// Shared core-wide constants and types for the RISC-V integer datapath.
package riscv_pkg;

   localparam int XLEN       = 64;
   localparam int REG_ADDR_W = 5;
   localparam int NUM_REGS   = 2 ** REG_ADDR_W;

   typedef logic [REG_ADDR_W-1:0] reg_idx_t;

endpackage

// File: rtl/register_file.sv
// Integer register file: two combinational read ports, one synchronous write port.
// x0 is never written and always reads as zero.
module register_file
   import riscv_pkg::*;
#(
   parameter int DATA_WIDTH = XLEN,
   parameter int ADDR_WIDTH = REG_ADDR_W
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] readRegister1,
   input  logic [ADDR_WIDTH-1:0] readRegister2,
   input  logic [ADDR_WIDTH-1:0] writeRegister,
   input  logic [DATA_WIDTH-1:0] writeData,
   input  logic                  regWrite,
   output logic [DATA_WIDTH-1:0] readData1,
   output logic [DATA_WIDTH-1:0] readData2
);

   localparam int NumEntries = 2 ** ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] regs [NumEntries];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NumEntries; i++) begin
            regs[i] <= '0;
         end
      end else if (regWrite && (writeRegister != '0)) begin
         regs[writeRegister] <= writeData;
      end
   end

   // No write-to-read bypass: forwarding lives in the pipeline, not here.
   assign readData1 = (readRegister1 == '0) ? '0 : regs[readRegister1];
   assign readData2 = (readRegister2 == '0) ? '0 : regs[readRegister2];

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: table-driven vectors plus hand-written
// reset and same-cycle sequences, compared through an expectation queue.
module tb_register_file;
   import riscv_pkg::*;

   logic             clk;
   logic             rst;
   reg_idx_t         readRegister1;
   reg_idx_t         readRegister2;
   reg_idx_t         writeRegister;
   logic [XLEN-1:0]  writeData;
   logic             regWrite;
   logic [XLEN-1:0]  readData1;
   logic [XLEN-1:0]  readData2;

   register_file #(.DATA_WIDTH(XLEN), .ADDR_WIDTH(REG_ADDR_W)) dut (
      .clk           (clk),
      .rst           (rst),
      .readRegister1 (readRegister1),
      .readRegister2 (readRegister2),
      .writeRegister (writeRegister),
      .writeData     (writeData),
      .regWrite      (regWrite),
      .readData1     (readData1),
      .readData2     (readData2)
   );

   initial begin
      clk = 1'b0;
      forever #50 clk = ~clk;
   end

   typedef struct {
      string           name;
      logic [XLEN-1:0] exp1;
      logic [XLEN-1:0] exp2;
   } exp_t;

   typedef struct {
      string           name;
      logic            we;
      reg_idx_t        wReg;
      logic [XLEN-1:0] wData;
      reg_idx_t        r1;
      reg_idx_t        r2;
      logic [XLEN-1:0] exp1;
      logic [XLEN-1:0] exp2;
   } vec_t;

   exp_t            expQ[$];
   vec_t            vecs[7];
   logic [XLEN-1:0] model [NUM_REGS];
   int              checks = 0;
   int              errors = 0;

   task automatic pushExp(input string name, input logic [XLEN-1:0] e1,
                          input logic [XLEN-1:0] e2);
      exp_t e;
      e.name = name;
      e.exp1 = e1;
      e.exp2 = e2;
      expQ.push_back(e);
   endtask

   task automatic popCheck();
      exp_t e;
      checks++;
      if (expQ.size() == 0) begin
         errors++;
         $display("FAIL scoreboard_empty: got pop with no expectation queued, required one entry");
      end else begin
         e = expQ.pop_front();
         if (readData1 !== e.exp1) begin
            errors++;
            $display("FAIL %s port1: got %h required %h", e.name, readData1, e.exp1);
         end
         checks++;
         if (readData2 !== e.exp2) begin
            errors++;
            $display("FAIL %s port2: got %h required %h", e.name, readData2, e.exp2);
         end
      end
   endtask

   initial begin
      vecs[0] = '{"wr_x1",        1'b1, 5'd1,  64'h1,                  5'd1,  5'd2,  64'h1, 64'h0};
      vecs[1] = '{"wr_x2",        1'b1, 5'd2,  64'h1,                  5'd1,  5'd2,  64'h1, 64'h1};
      vecs[2] = '{"we_low_x3",    1'b0, 5'd3,  64'hFFFF_FFFF_FFFF_FFFF, 5'd3,  5'd2,  64'h0, 64'h1};
      vecs[3] = '{"x0_hardwired", 1'b1, 5'd0,  64'h1234,               5'd0,  5'd0,  64'h0, 64'h0};
      vecs[4] = '{"wr_x5",        1'b1, 5'd5,  64'h7,                  5'd5,  5'd5,  64'h7, 64'h7};
      vecs[5] = '{"wr_x31_full",  1'b1, 5'd31, 64'hA5A5_A5A5_5A5A_5A5A, 5'd31, 5'd31,
                  64'hA5A5_A5A5_5A5A_5A5A, 64'hA5A5_A5A5_5A5A_5A5A};
      vecs[6] = '{"hold_we_low",  1'b0, 5'd31, 64'h0,                  5'd31, 5'd5,
                  64'hA5A5_A5A5_5A5A_5A5A, 64'h7};

      // Reset held across an edge with a write pending: reset must win.
      rst = 1'b1;
      regWrite = 1'b1;
      writeRegister = 5'd1;
      writeData = 64'hDEAD;
      readRegister1 = 5'd1;
      readRegister2 = 5'd2;
      #10;
      pushExp("in_reset", 64'h0, 64'h0);
      popCheck();
      #50;
      regWrite = 1'b0;
      #20;
      rst = 1'b0;
      #10;
      pushExp("after_reset_x1", 64'h0, 64'h0);
      popCheck();

      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         regWrite = vecs[i].we;
         writeRegister = vecs[i].wReg;
         writeData = vecs[i].wData;
         readRegister1 = vecs[i].r1;
         readRegister2 = vecs[i].r2;
         pushExp(vecs[i].name, vecs[i].exp1, vecs[i].exp2);
         @(posedge clk);
         #1;
         popCheck();
      end

      // Pending write to the register being read: old value until the edge.
      @(negedge clk);
      regWrite = 1'b1;
      writeRegister = 5'd5;
      writeData = 64'h9;
      readRegister1 = 5'd5;
      readRegister2 = 5'd31;
      #1;
      pushExp("pre_edge_x5", 64'h7, 64'hA5A5_A5A5_5A5A_5A5A);
      popCheck();
      @(posedge clk);
      #1;
      pushExp("post_edge_x5", 64'h9, 64'hA5A5_A5A5_5A5A_5A5A);
      popCheck();

      // Load x1..x31 with index*3 and mirror it in the model.
      for (int i = 0; i < NUM_REGS; i++) model[i] = '0;
      for (int i = 1; i < NUM_REGS; i++) begin
         @(negedge clk);
         regWrite = 1'b1;
         writeRegister = reg_idx_t'(i);
         writeData = 64'(i * 3);
         model[i] = 64'(i * 3);
      end
      @(negedge clk);
      regWrite = 1'b0;
      for (int i = 1; i < NUM_REGS; i += 6) begin
         readRegister1 = reg_idx_t'(i);
         readRegister2 = reg_idx_t'(NUM_REGS - i);
         #1;
         pushExp($sformatf("load_x%0d", i), model[i], model[NUM_REGS - i]);
         popCheck();
      end

      // Reset pulse between edges; every register must read zero with no clock edge.
      @(negedge clk);
      #1;
      rst = 1'b1;
      for (int i = 0; i < NUM_REGS; i++) model[i] = '0;
      for (int i = 1; i < NUM_REGS; i++) begin
         readRegister1 = reg_idx_t'(i);
         readRegister2 = reg_idx_t'(NUM_REGS - i);
         #1;
         pushExp($sformatf("async_clr_x%0d", i), model[i], model[NUM_REGS - i]);
         popCheck();
      end
      #5;
      rst = 1'b0;
      #1;
      pushExp("post_pulse_x31", 64'h0, 64'h0);
      popCheck();

      // Writes resume on the next qualifying edge.
      @(negedge clk);
      regWrite = 1'b1;
      writeRegister = 5'd7;
      writeData = 64'h55;
      readRegister1 = 5'd7;
      readRegister2 = 5'd8;
      @(posedge clk);
      #1;
      pushExp("resume_x7", 64'h55, 64'h0);
      popCheck();
      @(negedge clk);
      regWrite = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, required test completion");
      $fatal(1, "watchdog expired");
   end

endmodule
